// File: rtl/mem_arb_pkg.sv
// Shared constants, state codes and data helpers for the byte-bus arbiter.
// Used by mem_bus_arbiter and mem_byte_seq.
package mem_arb_pkg;

    localparam int LSB_TYPE_W = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_READ    = 2'd1;
    localparam state_t ST_WRITE   = 2'd2;
    localparam state_t ST_IO_WAIT = 2'd3;

    localparam logic [1:0] IO_HI = 2'b11;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_LSB = 1'b1;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = uns ? {24'b0, w[7:0]}
                             : {{24{w[7]}}, w[7:0]};
            SZ_HALF: r = uns ? {16'b0, w[15:0]}
                             : {{16{w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Splits one 1/2/4-byte access into consecutive byte bus cycles and
// assembles read bytes little-endian; done marks the last bus cycle.
module mem_byte_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        n,
    input  logic              is_write,
    input  logic [31:0]       wdata,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        dout,
    output logic              wr,
    output logic [31:0]       word,
    output logic              done
);

    logic              busy;
    logic              kind;
    logic [2:0]        k;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lanes;
    logic [2:0]        lane_k;
    logic              cap;
    logic [ADDR_W-1:0] next_addr;

    // k is the index of the byte driven next; a read byte lands two
    // counts later because the memory answers one cycle late.
    assign lane_k    = k - 3'd2;
    assign cap       = busy && !kind && (k >= 3'd2);
    assign next_addr = base_q + {{(ADDR_W-3){1'b0}}, k};
    assign done      = busy && (kind ? (k == n_q)
                                     : (k == n_q + 3'd1));

    always_comb begin
        word = lanes;
        if (cap) begin
            word[{lane_k[1:0], 3'b000} +: 8] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            kind    <= 1'b0;
            k       <= 3'd0;
            n_q     <= 3'd0;
            base_q  <= '0;
            wdata_q <= 32'd0;
            lanes   <= 32'd0;
            addr    <= '0;
            dout    <= 8'd0;
            wr      <= 1'b0;
        end else if (en) begin
            if (start) begin
                busy    <= 1'b1;
                kind    <= is_write;
                k       <= 3'd1;
                n_q     <= n;
                base_q  <= base;
                wdata_q <= wdata;
                lanes   <= 32'd0;
                addr    <= base;
                dout    <= wdata[7:0];
                wr      <= is_write;
            end else if (abort) begin
                busy  <= 1'b0;
                k     <= 3'd0;
                lanes <= 32'd0;
                wr    <= 1'b0;
            end else if (busy) begin
                lanes <= word;
                if (done) begin
                    busy <= 1'b0;
                    wr   <= 1'b0;
                end else begin
                    k <= k + 3'd1;
                    if (k < n_q) begin
                        addr <= next_addr;
                        dout <= wdata_q[{k[1:0], 3'b000} +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Byte-bus arbiter between instruction fetch and the load/store buffer.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties.
module mem_bus_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = mem_arb_pkg::IO_HI
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              flush,
    input  logic [7:0]                        mem_din,
    output logic [7:0]                        mem_dout,
    output logic [ADDR_W-1:0]                 mem_a,
    output logic                              mem_wr,
    input  logic                              io_buffer_full,
    input  logic                              if_en,
    input  logic [ADDR_W-1:0]                 if_addr,
    output logic                              if_rdy,
    output logic [31:0]                       if_data,
    input  logic                              lsb_en,
    input  logic [ADDR_W-1:0]                 lsb_addr,
    input  logic [mem_arb_pkg::LSB_TYPE_W-1:0] lsb_type,
    input  logic [31:0]                       lsb_wdata,
    output logic                              lsb_rdy,
    output logic [31:0]                       lsb_rdata
);

    import mem_arb_pkg::*;

    state_t            st;
    logic              owner;
    logic              uns_q;
    logic [1:0]        sz_q;
    logic [ADDR_W-1:0] a_q;
    logic [31:0]       wd_q;
    logic [2:0]        n_q;
    logic              if_rdy_q;
    logic              lsb_rdy_q;
    logic              pulse_rd;
    logic              mem_wr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant;
`endif

    logic              can_grant;
    logic              pick_lsb;
    logic              go;
    logic [ADDR_W-1:0] g_addr;
    logic              g_wr;
    logic [2:0]        g_n;
    logic              io_stall;
    logic              wait_done;
    logic              seq_start;
    logic              seq_abort;
    logic              seq_done;
    logic [ADDR_W-1:0] s_base;
    logic [2:0]        s_n;
    logic              s_wr;
    logic [31:0]       s_wdata;
    logic [31:0]       seq_word;

    // A pending pulse blocks the grant so the owner can drop its request.
    assign can_grant = (st == ST_IDLE) && !if_rdy_q
                    && !lsb_rdy_q && !flush;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign pick_lsb = lsb_en && (!if_en || (last_grant == REQ_IF));
`else
    assign pick_lsb = lsb_en;
`endif

    assign go       = can_grant && (lsb_en || if_en);
    assign g_addr   = pick_lsb ? lsb_addr : if_addr;
    assign g_wr     = pick_lsb && lsb_type[3];
    assign g_n      = pick_lsb ? size_bytes(lsb_type[1:0]) : 3'd4;
    assign io_stall = g_wr && (g_addr[17:16] == IO_HI)
                   && io_buffer_full;

    assign wait_done = (st == ST_IO_WAIT) && !io_buffer_full;
    assign seq_start = (go && !io_stall) || wait_done;
    assign seq_abort = (st == ST_READ) && flush;
    assign s_base    = wait_done ? a_q  : g_addr;
    assign s_n       = wait_done ? n_q  : g_n;
    assign s_wr      = wait_done ? 1'b1 : g_wr;
    assign s_wdata   = wait_done ? wd_q : lsb_wdata;

    mem_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk      (clk_in),
        .rst_n    (rst_in),
        .en       (rdy_in),
        .start    (seq_start),
        .abort    (seq_abort),
        .base     (s_base),
        .n        (s_n),
        .is_write (s_wr),
        .wdata    (s_wdata),
        .din      (mem_din),
        .addr     (mem_a),
        .dout     (mem_dout),
        .wr       (mem_wr_q),
        .word     (seq_word),
        .done     (seq_done)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            st         <= ST_IDLE;
            owner      <= REQ_IF;
            uns_q      <= 1'b0;
            sz_q       <= 2'd0;
            a_q        <= '0;
            wd_q       <= 32'd0;
            n_q        <= 3'd0;
            if_rdy_q   <= 1'b0;
            lsb_rdy_q  <= 1'b0;
            pulse_rd   <= 1'b0;
            if_data    <= 32'd0;
            lsb_rdata  <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= REQ_LSB;
`endif
        end else if (rdy_in) begin
            if_rdy_q  <= 1'b0;
            lsb_rdy_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (go) begin
                        owner <= pick_lsb;
                        uns_q <= lsb_type[2];
                        sz_q  <= lsb_type[1:0];
                        a_q   <= g_addr;
                        wd_q  <= lsb_wdata;
                        n_q   <= g_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= pick_lsb;
`endif
                        if (io_stall) begin
                            st <= ST_IO_WAIT;
                        end else if (g_wr) begin
                            st <= ST_WRITE;
                        end else begin
                            st <= ST_READ;
                        end
                    end
                end
                ST_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        st <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        st <= ST_IDLE;
                    end else if (seq_done) begin
                        st       <= ST_IDLE;
                        pulse_rd <= 1'b1;
                        if (owner == REQ_LSB) begin
                            lsb_rdy_q <= 1'b1;
                            lsb_rdata <= extend(seq_word, sz_q, uns_q);
                        end else begin
                            if_rdy_q <= 1'b1;
                            if_data  <= seq_word;
                        end
                    end
                end
                ST_WRITE: begin
                    if (seq_done) begin
                        st        <= ST_IDLE;
                        pulse_rd  <= 1'b0;
                        lsb_rdy_q <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // A frozen cycle must not repeat a write; a late flush drops read results.
    assign mem_wr  = mem_wr_q & rdy_in;
    assign if_rdy  = if_rdy_q & ~flush;
    assign lsb_rdy = lsb_rdy_q & ~(flush & pulse_rd);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Owns the single byte-wide memory/IO bus.
- Shares it between two requesters: instruction fetch (always a 4-byte word) and the load/store buffer (1/2/4-byte loads and stores).
- Sequences each multi-byte access into per-byte bus cycles and assembles read data little-endian.
- Returns a one-cycle ready pulse to the requester that owns the transaction.

Parameters:
- ADDR_W, 32, width of request addresses and mem_a.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO space.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low freezes all state
- flush  in  1  mispredict flush
- mem_din  in  8  read byte, valid the cycle after its address was driven
- mem_dout  out  8  write byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  uart tx buffer full
- if_en  in  1  fetch request, level, held until if_rdy
- if_addr  in  ADDR_W  fetch address
- if_rdy  out  1  one-cycle completion pulse
- if_data  out  32  fetched word
- lsb_en  in  1  load/store request, level, held until lsb_rdy
- lsb_addr  in  ADDR_W  access address
- lsb_type  in  LSB_TYPE_W  {is_write, is_unsigned, size[1:0]}; size 0=byte, 1=half, 2=word
- lsb_wdata  in  32  store data
- lsb_rdy  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, sign- or zero-extended

Behaviour:
- Reset (rst_in low at a clock edge) puts the block in IDLE.
  - Clears mem_a, mem_dout, mem_wr, if_rdy, if_data, lsb_rdy, lsb_rdata and all counters to 0.
  - Reset mid-transaction abandons the transaction silently.
- rdy_in low:
  - All registers hold.
  - mem_wr is forced to 0 combinationally so no write repeats.
- States: IDLE, READ, WRITE, IO_WAIT.
- IDLE grant:
  - lsb_en has priority over if_en; the grant is latched with the address, type and n = byte count.
  - A request raised in the same cycle as a completion pulse is sampled next cycle. One idle cycle minimum between transactions.
- READ:
  - Byte k address = base+k, driven on cycle k after grant, k = 0..n-1.
  - mem_din captured on cycles 1..n into byte lane k.
  - The rdy pulse is asserted on cycle n+1 with assembled data: 5 cycles for fetch or word load, 2 for a byte load.
  - Extension is by size and is_unsigned.
- WRITE:
  - mem_wr=1 and mem_dout = wdata byte k on cycle k.
  - lsb_rdy pulses on cycle n, and the FSM returns to IDLE.
- IO_WAIT:
  - Entered from grant when is_write, addr[17:16]==IO_HI and io_buffer_full=1.
  - mem_wr stays 0 until io_buffer_full=0, then proceeds to WRITE.
- IO reads use the same READ path with no stall.
- flush:
  - Aborts a fetch or a load in progress (READ): return to IDLE next cycle, no rdy pulse, lane registers cleared.
  - Stores (WRITE/IO_WAIT) are committed and are never aborted.
  - A flush coinciding with the rdy pulse cycle suppresses that pulse for fetches and loads.
- Address arithmetic wraps modulo 2^ADDR_W. There is no alignment check; misaligned halves and words are split bytewise.
- Unused if_* and lsb_* outputs hold their last value; only the rdy pulses are meaningful.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN
  - Defined: grant alternates when both are requesting. The requester served last loses a tie; a last_grant flop resets to "lsb" so fetch wins the first tie.
  - Undefined: fixed LSB priority, which can starve fetch for as long as lsb_en stays high.

Decomposition:
- Shared package mem_arb_pkg holds:
  - LSB_TYPE_W, the size encodings, and the state enum.
  - IO_HI and the requester-id constants.
- One sub-module, mem_byte_seq. It takes base address, n, is_write and wdata. It produces mem_a/mem_dout/mem_wr, the assembled 32-bit word and a done strobe.
- The arbiter keeps the grant, flush, IO-stall logic and extension.

Test Plan:
- Fetch 0x1000, memory holds bytes 13 05 00 00 -> mem_a 0x1000..0x1003 on cycles 0-3; if_rdy on cycle 5 with if_data=0x00000513.
- Load byte signed at 0x2000 = 0x80 -> lsb_rdata=0xFFFFFF80 on cycle 2. Same access with is_unsigned=1 -> 0x00000080.
- Store word 0xDEADBEEF to 0x40 -> bytes EF, BE, AD, DE with mem_wr=1 at 0x40..0x43; lsb_rdy on cycle 4.
- Write byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write; flush during the stall does not cancel it.
- if_en and lsb_en raised together -> LSB served first (round-robin off). Flush on fetch cycle 2 -> no if_rdy, IDLE on the next cycle.
- rdy_in low for 2 cycles mid-read -> mem_wr=0, result identical and delayed by 2; rst_in low mid-write -> all outputs 0 next cycle.
